// File: rtl/gf3_row_normalize.sv
`default_nettype none
// ============================================================================
// Module   : gf3_row_normalize
// Purpose  : Scales a GF(3) row so its leading nonzero element becomes 1,
//            using an external inverter port for the pivot inverse.
// Revision : 1.0 - initial release
// ============================================================================
module gf3_row_normalize #(
  parameter  int N         = 8,
  parameter  int INV_DELAY = 1,
  localparam int IDX_W     = ($clog2(N) > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2*N-1:0]   in_row,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [1:0]       inv_din,
  input  logic [1:0]       inv_dout,
  input  logic             inv_dout_en,
  output logic [2*N-1:0]   out_row,
  output logic [IDX_W-1:0] out_pivot,
  output logic             out_singular,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SCAN     = 2'd1,
    INV_WAIT = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N - 1);
  localparam logic [2:0]       c_inv_dly  = 3'(INV_DELAY);

  state_t           r_state;
  state_t           w_next;
  logic [2*N-1:0]   r_row;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_pivot;
  logic [2:0]       r_wait;
  logic [1:0]       r_inv_din;
  logic [2*N-1:0]   r_out_row;
  logic [IDX_W-1:0] r_out_pivot;
  logic             r_out_sing;

  logic [1:0]       w_elem [N];
  logic [2*N-1:0]   w_clean_row;
  logic [2*N-1:0]   w_scaled_row;
  logic [1:0]       w_cur;
  logic             w_cur_nz;
  logic             w_last;
  logic             w_sample;
  logic             w_in_ready;
  logic             w_out_valid;

  // Illegal code 11 behaves as 0 in both the scan and the product
  function automatic logic [1:0] gf3_mul(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] r;
    r = 2'b00;
    if (a != 2'b00 && a != 2'b11 && b != 2'b00 && b != 2'b11)
      r = (a == b) ? 2'b01 : 2'b10;
    return r;
  endfunction

  for (genvar gi = 0; gi < N; gi++) begin : g_elem
    assign w_elem[gi]                = (r_row[2*gi +: 2] == 2'b11) ? 2'b00 : r_row[2*gi +: 2];
    assign w_clean_row[2*gi +: 2]    = w_elem[gi];
    assign w_scaled_row[2*gi +: 2]   = gf3_mul(w_elem[gi], inv_dout);
  end

  assign w_cur    = w_elem[r_idx];
  assign w_cur_nz = (w_cur != 2'b00);
  assign w_last   = (r_idx == c_last_idx);
  assign w_sample = (r_wait == c_inv_dly);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) w_next = SCAN;
      end
      SCAN: begin
        if (w_cur_nz)    w_next = INV_WAIT;
        else if (w_last) w_next = DONE;
      end
      INV_WAIT: begin
        if (w_sample) w_next = DONE;
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_row       <= '0;
      r_idx       <= '0;
      r_pivot     <= '0;
      r_wait      <= '0;
      r_inv_din   <= '0;
      r_out_row   <= '0;
      r_out_pivot <= '0;
      r_out_sing  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_row  <= in_row;
            r_idx  <= '0;
            r_wait <= '0;
          end
        end
        SCAN: begin
          if (w_cur_nz) begin
            r_pivot   <= r_idx;
            r_inv_din <= w_cur;
            r_wait    <= '0;
          end else if (w_last) begin
            r_out_row   <= w_clean_row;
            r_out_pivot <= '0;
            r_out_sing  <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        INV_WAIT: begin
          r_wait <= r_wait + 3'd1;
          // A missing inverse is a protocol fault; report it as singular
          if (w_sample) begin
            if (inv_dout_en) begin
              r_out_row   <= w_scaled_row;
              r_out_pivot <= r_pivot;
              r_out_sing  <= 1'b0;
            end else begin
              r_out_row   <= w_clean_row;
              r_out_pivot <= '0;
              r_out_sing  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready     = w_in_ready;
  assign out_valid    = w_out_valid;
  assign inv_din      = r_inv_din;
  assign out_row      = r_out_row;
  assign out_pivot    = r_out_pivot;
  assign out_singular = r_out_sing;

endmodule
`default_nettype wire

// File: tb/tb_gf3_row_normalize.sv
`default_nettype none
// ============================================================================
// Module   : tb_gf3_row_normalize
// Purpose  : Self-checking bench for gf3_row_normalize with an inverter model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gf3_row_normalize;

  localparam int N  = 8;
  localparam int D  = 1;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2*N-1:0] in_row;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    inv_din;
  logic [1:0]    inv_dout;
  logic          inv_dout_en;
  logic [2*N-1:0] out_row;
  logic [IW-1:0] out_pivot;
  logic          out_singular;
  logic          out_valid;
  logic          out_ready;
  logic          inv_fault;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  gf3_row_normalize #(.N(N), .INV_DELAY(D)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_row       (in_row),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .inv_din      (inv_din),
    .inv_dout     (inv_dout),
    .inv_dout_en  (inv_dout_en),
    .out_row      (out_row),
    .out_pivot    (out_pivot),
    .out_singular (out_singular),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  // One-cycle GF(3) inverter: finds x with d*x = 1 mod 3
  always @(posedge clk) begin
    int x;
    x = 0;
    for (int c = 1; c < 3; c++)
      if ((int'(inv_din) * c) % 3 == 1) x = c;
    inv_dout    <= 2'(x);
    inv_dout_en <= (x != 0) && !inv_fault;
  end

  typedef struct {
    logic [2*N-1:0] row;
    logic [2*N-1:0] orow;
    int             piv;
    bit             sing;
    int             lat;
    bit             drv;
    logic [1:0]     inv;
    int             hold;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2*N-1:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7);
    int e[8];
    logic [2*N-1:0] r;
    e = '{a0, a1, a2, a3, a4, a5, a6, a7};
    for (int i = 0; i < 8; i++) r[2*i +: 2] = 2'(e[i]);
    return r;
  endfunction

  // Reference: leading nonzero element, its GF(3) inverse, scaled row, latency
  task automatic model(input logic [2*N-1:0] row, output logic [2*N-1:0] orow,
                       output int piv, output bit sing, output int lat, output logic [1:0] pv);
    int v[N];
    int inv;
    piv = -1;
    inv = 0;
    for (int i = 0; i < N; i++) begin
      v[i] = int'(row[2*i +: 2]);
      if (v[i] == 3) v[i] = 0;
      if (piv < 0 && v[i] != 0) piv = i;
    end
    orow = '0;
    pv   = 2'd0;
    if (piv < 0) begin
      sing = 1'b1;
      piv  = 0;
      lat  = N + 1;
      for (int i = 0; i < N; i++) orow[2*i +: 2] = 2'(v[i]);
    end else begin
      sing = 1'b0;
      pv   = 2'(v[piv]);
      for (int c = 1; c < 3; c++) if ((v[piv] * c) % 3 == 1) inv = c;
      for (int i = 0; i < N; i++) orow[2*i +: 2] = 2'((v[i] * inv) % 3);
      lat = piv + 3 + D;
    end
  endtask

  // Entered and left at a falling edge
  task automatic run_row(input logic [2*N-1:0] row, input logic [2*N-1:0] orow,
                         input int piv, input bit sing, input int lat, input bit drv,
                         input logic [1:0] inv, input int hold, input bit fault);
    logic [1:0] prev_inv;
    int guard;
    int cyc;
    prev_inv  = inv_din;
    inv_fault = fault;
    in_row    = row;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("accept_timeout", 64'(guard), 64'(0));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      if (drv && cyc == lat - 1 - D) chk("inv_din", 64'(inv_din), 64'(inv));
      @(negedge clk);
      cyc++;
    end
    chk("latency", 64'(cyc), 64'(lat));
    chk("out_row", 64'(out_row), 64'(orow));
    chk("out_pivot", 64'(out_pivot), 64'(piv));
    chk("out_singular", 64'(out_singular), 64'(sing));
    if (!drv) chk("inv_din_kept", 64'(inv_din), 64'(prev_inv));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'(1));
      chk("hold_row", 64'(out_row), 64'(orow));
      chk("hold_in_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_in_ready", 64'(in_ready), 64'(1));
    chk("post_valid", 64'(out_valid), 64'(0));
    out_ready = 1'b0;
    inv_fault = 1'b0;
  endtask

  initial begin
    logic [2*N-1:0] r, o;
    int p, l, h, e;
    bit s;
    logic [1:0] pv;

    tbl[0] = '{pk(2,1,0,2,1,1,0,2), pk(1,2,0,1,2,2,0,1), 0, 1'b0, 4,  1'b1, 2'd2, 0};
    tbl[1] = '{pk(0,0,0,0,0,0,0,0), pk(0,0,0,0,0,0,0,0), 0, 1'b1, 9,  1'b0, 2'd0, 2};
    tbl[2] = '{pk(0,0,0,0,0,0,0,2), pk(0,0,0,0,0,0,0,1), 7, 1'b0, 11, 1'b1, 2'd2, 1};
    tbl[3] = '{pk(0,3,1,2,0,0,0,0), pk(0,0,1,2,0,0,0,0), 2, 1'b0, 6,  1'b1, 2'd1, 0};
    tbl[4] = '{pk(0,1,2,3,2,1,0,1), pk(0,1,2,0,2,1,0,1), 1, 1'b0, 5,  1'b1, 2'd1, 5};
    tbl[5] = '{pk(3,3,3,3,3,3,3,3), pk(0,0,0,0,0,0,0,0), 0, 1'b1, 9,  1'b0, 2'd0, 0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_row = '0; inv_fault = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_row", 64'(out_row), 64'(0));
    chk("rst_out_pivot", 64'(out_pivot), 64'(0));
    chk("rst_out_singular", 64'(out_singular), 64'(0));
    chk("rst_inv_din", 64'(inv_din), 64'(0));
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      run_row(tbl[i].row, tbl[i].orow, tbl[i].piv, tbl[i].sing, tbl[i].lat,
              tbl[i].drv, tbl[i].inv, tbl[i].hold, 1'b0);

    // Inverter reports no inverse: row is returned as singular
    run_row(pk(0,2,1,0,0,0,0,3), pk(0,2,1,0,0,0,0,0), 0, 1'b1, 5, 1'b1, 2'd2, 1, 1'b1);

    // Reset pulse while waiting on the inverter
    in_row = pk(2,2,1,0,0,0,0,0);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_out_row", 64'(out_row), 64'(0));
    chk("midrst_out_pivot", 64'(out_pivot), 64'(0));
    chk("midrst_out_singular", 64'(out_singular), 64'(0));
    chk("midrst_inv_din", 64'(inv_din), 64'(0));
    @(negedge clk);
    chk("midrst_idle_valid", 64'(out_valid), 64'(0));
    chk("midrst_idle_ready", 64'(in_ready), 64'(1));
    run_row(pk(0,0,1,2,1,0,2,0), pk(0,0,1,2,1,0,2,0), 2, 1'b0, 6, 1'b1, 2'd1, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < N; i++) begin
        e = int'($urandom_range(0, 6));
        r[2*i +: 2] = (e > 3) ? 2'd0 : 2'(e);
      end
      model(r, o, p, s, l, pv);
      h = int'($urandom_range(0, 3));
      run_row(r, o, p, s, l, !s, pv, h, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
